pipeline_stall_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Merges four sources into one consistent set of pipeline-register enables and flushes:
  - load-use stall request from the hazard detector;
  - multi-cycle mul/div occupancy of EX;
  - EX-stage branch-taken;
  - ID-stage jump.
- Sits beside the hazard detector and drives PC, IF/ID, ID/EX and EX/MEM control.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipeline_stall_controller.sv | 124 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, mul/div occupancy,
// branch-taken and jump into pipeline-register enables/flushes, with saturating perf counters.
module pipeline_stall_controller #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned PERF_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              load_use_i,
  input  logic              md_issue_i,
  input  logic              branch_taken_i,
  input  logic              jump_i,
  output logic              PC_Write,
  output logic              IF_ID_write,
  output logic              IF_ID_flush,
  output logic              ID_EX_write,
  output logic              ID_EX_flush,
  output logic              EX_MEM_bubble,
  output logic              md_busy_o,
  output logic              md_done_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  // Counter preload; a single-cycle mul/div never enters MD_WAIT, so its value is unused.
  localparam logic [CNT_W-1:0] MD_INIT = (MD_LATENCY > 1) ? CNT_W'(MD_LATENCY - 2) : '0;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_md_cnt;
  logic [CNT_W-1:0]   w_md_cnt_next;
  logic [PERF_W-1:0]  r_stall_cnt;
  logic [PERF_W-1:0]  r_flush_cnt;
  logic               w_md_start;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_next_state;
      r_md_cnt <= w_md_cnt_next;
    end
  end

  assign w_md_start = (r_state == RUN) && !branch_taken_i && !load_use_i && md_issue_i
                      && (MD_LATENCY > 1);

  always_comb begin
    w_next_state  = r_state;
    w_md_cnt_next = r_md_cnt;
    case (r_state)
      RUN: begin
        if (w_md_start) begin
          w_next_state  = MD_WAIT;
          w_md_cnt_next = MD_INIT;
        end
      end
      MD_WAIT: begin
        if (r_md_cnt == '0) begin
          w_next_state = RUN;
        end else begin
          w_md_cnt_next = r_md_cnt - CNT_W'(1);
        end
      end
      default: w_next_state = RUN;
    endcase
  end

  always_comb begin
    PC_Write      = 1'b1;
    IF_ID_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_write   = 1'b1;
    ID_EX_flush   = 1'b0;
    EX_MEM_bubble = 1'b0;
    md_busy_o     = 1'b0;
    md_done_o     = 1'b0;
    case (r_state)
      RUN: begin
        if (branch_taken_i) begin
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
        end else if (load_use_i) begin
          PC_Write    = 1'b0;
          IF_ID_write = 1'b0;
          ID_EX_flush = 1'b1;
        end else if (!md_issue_i && jump_i) begin
          IF_ID_flush = 1'b1;
        end
      end
      MD_WAIT: begin
        PC_Write      = 1'b0;
        IF_ID_write   = 1'b0;
        ID_EX_write   = 1'b0;
        EX_MEM_bubble = 1'b1;
        md_busy_o     = 1'b1;
        md_done_o     = (r_md_cnt == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!PC_Write && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      end
      if (IF_ID_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + PERF_W'(1);
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: default instance plus a MD_LATENCY=1 / PERF_W=4 instance on shared inputs.
module tb_pipeline_stall_controller;

  logic clk;
  logic rst_n;
  logic load_use, md_issue, branch_taken, jump;

  logic        a_pcw, a_ifw, a_iff, a_idw, a_idf, a_exb, a_busy, a_done;
  logic [15:0] a_stall, a_flush;
  logic        b_pcw, b_ifw, b_iff, b_idw, b_idf, b_exb, b_busy, b_done;
  logic [3:0]  b_stall, b_flush;

  logic [7:0] a_ctrl, b_ctrl;
  assign a_ctrl = {a_pcw, a_ifw, a_iff, a_idw, a_idf, a_exb, a_busy, a_done};
  assign b_ctrl = {b_pcw, b_ifw, b_iff, b_idw, b_idf, b_exb, b_busy, b_done};

  localparam logic [7:0] C_BASE   = 8'b1101_0000;
  localparam logic [7:0] C_LDUSE  = 8'b0001_1000;
  localparam logic [7:0] C_MDWAIT = 8'b0000_0110;
  localparam logic [7:0] C_MDDONE = 8'b0000_0111;
  localparam logic [7:0] C_BRANCH = 8'b1111_1000;
  localparam logic [7:0] C_JUMP   = 8'b1111_0000;

  int unsigned vec;
  int unsigned miss;

  pipeline_stall_controller #(.MD_LATENCY(4), .CNT_W(3), .PERF_W(16)) dut (
    .clk_i(clk), .rst_n(rst_n), .load_use_i(load_use), .md_issue_i(md_issue),
    .branch_taken_i(branch_taken), .jump_i(jump),
    .PC_Write(a_pcw), .IF_ID_write(a_ifw), .IF_ID_flush(a_iff), .ID_EX_write(a_idw),
    .ID_EX_flush(a_idf), .EX_MEM_bubble(a_exb), .md_busy_o(a_busy), .md_done_o(a_done),
    .stall_cnt_o(a_stall), .flush_cnt_o(a_flush)
  );

  pipeline_stall_controller #(.MD_LATENCY(1), .CNT_W(3), .PERF_W(4)) dut_b (
    .clk_i(clk), .rst_n(rst_n), .load_use_i(load_use), .md_issue_i(md_issue),
    .branch_taken_i(branch_taken), .jump_i(jump),
    .PC_Write(b_pcw), .IF_ID_write(b_ifw), .IF_ID_flush(b_iff), .ID_EX_write(b_idw),
    .ID_EX_flush(b_idf), .EX_MEM_bubble(b_exb), .md_busy_o(b_busy), .md_done_o(b_done),
    .stall_cnt_o(b_stall), .flush_cnt_o(b_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a new input vector at the falling edge, then settle before sampling.
  task automatic drive(input logic lu, input logic md, input logic br, input logic jp);
    @(negedge clk);
    load_use = lu; md_issue = md; branch_taken = br; jump = jp;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    load_use = 0; md_issue = 0; branch_taken = 0; jump = 0;
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_use = 0; md_issue = 0; branch_taken = 0; jump = 0;
    #3;
    vec++; if (a_ctrl !== C_BASE) begin miss++; $display("FAIL reset_ctrl got %b exp %b", a_ctrl, C_BASE); end
    vec++; if (a_stall !== 16'd0 || a_flush !== 16'd0) begin miss++;
      $display("FAIL reset_cnt got %0d/%0d exp 0/0", a_stall, a_flush); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0);
      vec++; if (a_ctrl !== C_BASE || a_stall !== 16'd0 || a_flush !== 16'd0) begin miss++;
        $display("FAIL idle[%0d] got ctrl %b cnt %0d/%0d exp %b 0/0", i, a_ctrl, a_stall, a_flush, C_BASE); end
    end
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0);
    vec++; if (a_ctrl !== C_LDUSE) begin miss++; $display("FAIL lduse_ctrl got %b exp %b", a_ctrl, C_LDUSE); end
    drive(0, 0, 0, 0);
    vec++; if (a_ctrl !== C_BASE) begin miss++; $display("FAIL lduse_after got %b exp %b", a_ctrl, C_BASE); end
    vec++; if (a_stall !== 16'd1) begin miss++; $display("FAIL lduse_stallcnt got %0d exp 1", a_stall); end
    vec++; if (b_stall !== 4'd1) begin miss++; $display("FAIL lduse_stallcnt_b got %0d exp 1", b_stall); end
  endtask

  task automatic test_md();
    drive(0, 1, 0, 0);
    vec++; if (a_ctrl !== C_BASE) begin miss++; $display("FAIL md_T got %b exp %b", a_ctrl, C_BASE); end
    drive(0, 0, 0, 0);
    vec++; if (a_ctrl !== C_MDWAIT) begin miss++; $display("FAIL md_T1 got %b exp %b", a_ctrl, C_MDWAIT); end
    vec++; if (b_ctrl !== C_BASE) begin miss++; $display("FAIL md_lat1_nostall got %b exp %b", b_ctrl, C_BASE); end
    drive(1, 1, 0, 1);
    vec++; if (a_ctrl !== C_MDWAIT) begin miss++; $display("FAIL md_T2_ignore got %b exp %b", a_ctrl, C_MDWAIT); end
    drive(0, 0, 0, 0);
    vec++; if (a_ctrl !== C_MDDONE) begin miss++; $display("FAIL md_T3_done got %b exp %b", a_ctrl, C_MDDONE); end
    drive(0, 0, 0, 0);
    vec++; if (a_ctrl !== C_BASE) begin miss++; $display("FAIL md_T4_run got %b exp %b", a_ctrl, C_BASE); end
    vec++; if (a_stall !== 16'd4) begin miss++; $display("FAIL md_stallcnt got %0d exp 4", a_stall); end
  endtask

  task automatic test_branch_priority();
    do_reset();
    drive(1, 1, 1, 1);
    vec++; if (a_ctrl !== C_BRANCH) begin miss++; $display("FAIL branch_ctrl got %b exp %b", a_ctrl, C_BRANCH); end
    drive(0, 0, 0, 0);
    vec++; if (a_ctrl !== C_BASE) begin miss++; $display("FAIL branch_staysrun got %b exp %b", a_ctrl, C_BASE); end
    vec++; if (a_flush !== 16'd1 || a_stall !== 16'd0) begin miss++;
      $display("FAIL branch_cnt got %0d/%0d exp flush 1 stall 0", a_flush, a_stall); end
  endtask

  task automatic test_jump_and_lduse_over_md();
    drive(0, 0, 0, 1);
    vec++; if (a_ctrl !== C_JUMP) begin miss++; $display("FAIL jump_ctrl got %b exp %b", a_ctrl, C_JUMP); end
    drive(1, 1, 0, 0);
    vec++; if (a_ctrl !== C_LDUSE) begin miss++; $display("FAIL lduse_md_ctrl got %b exp %b", a_ctrl, C_LDUSE); end
    drive(0, 0, 0, 0);
    vec++; if (a_ctrl !== C_BASE) begin miss++; $display("FAIL lduse_md_noissue got %b exp %b", a_ctrl, C_BASE); end
    vec++; if (a_flush !== 16'd2 || a_stall !== 16'd1) begin miss++;
      $display("FAIL jump_cnt got %0d/%0d exp flush 2 stall 1", a_flush, a_stall); end
  endtask

  task automatic test_reset_mid_md();
    do_reset();
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    vec++; if (a_ctrl !== C_MDWAIT) begin miss++; $display("FAIL midmd_pre got %b exp %b", a_ctrl, C_MDWAIT); end
    rst_n = 1'b0;
    #1;
    vec++; if (a_ctrl !== C_BASE) begin miss++; $display("FAIL midmd_async got %b exp %b", a_ctrl, C_BASE); end
    vec++; if (a_stall !== 16'd0 || a_flush !== 16'd0) begin miss++;
      $display("FAIL midmd_cnt got %0d/%0d exp 0/0", a_stall, a_flush); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0);
      vec++; if (a_ctrl !== C_BASE) begin miss++; $display("FAIL midmd_post[%0d] got %b exp %b", i, a_ctrl, C_BASE); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0);
      vec++; if (b_stall !== 4'((i > 15) ? 15 : i)) begin miss++;
        $display("FAIL sat[%0d] got %0d exp %0d", i, b_stall, (i > 15) ? 15 : i); end
    end
    drive(0, 0, 0, 0);
    vec++; if (b_stall !== 4'd15) begin miss++; $display("FAIL sat_hold got %0d exp 15", b_stall); end
    vec++; if (a_stall !== 16'd20) begin miss++; $display("FAIL sat_wide got %0d exp 20", a_stall); end
  endtask

  initial begin
    vec = 0; miss = 0;
    test_reset();
    test_load_use();
    test_md();
    test_branch_priority();
    test_jump_and_lduse_over_md();
    test_reset_mid_md();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
